// File: rtl/press_evt_pkg.sv
// Shared types for the press event encoder.
//   evt_type_e : event type carried in the top two bits of each event word
//   state_e    : press tracking states
//   evt_t      : packed event word {type, duration} at the default counter width
package press_evt_pkg;

    localparam int unsigned EVT_CNT_W = 16;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'b00,
        EVT_SHORT = 2'b01,
        EVT_LONG  = 2'b10,
        EVT_HOLD  = 2'b11
    } evt_type_e;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        PRESSED
    } state_e;

    // "type" is a keyword, hence evt_type.
    typedef struct packed {
        evt_type_e              evt_type;
        logic [EVT_CNT_W-1:0]   dur;
    } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, empties the FIFO
//   push_i   : write data_i; accepted when not full or when a pop happens this cycle
//   data_i   : write data
//   pop_i    : remove the head entry (ignored when empty)
//   data_o   : head entry, meaningful only when not empty
//   full_o   : count_o == Depth
//   empty_o  : count_o == 0
//   count_o  : occupancy, 0..Depth
module evt_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 18,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign pop_ok  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/press_event_encoder.sv
// Press event encoder: turns a debounced switch level into queued press events.
// Each press is measured in clock cycles (saturating) and classified SHORT or LONG
// at release; events go through a small FWFT FIFO with a valid/ready port.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   db_i         : debounced switch level
//   evt_valid_o  : FIFO head holds an event
//   evt_ready_i  : consumer takes the head event this cycle
//   evt_data_o   : {type[1:0], duration[CNT_W-1:0]}, zero while not valid
//   overflow_o   : sticky, an event was dropped on a full FIFO; cleared by rst
// Optional build macro PRESS_HOLD_EVT_EN: emit one HOLD event per press at the
// cycle the duration reaches LONG_TH (the release still emits LONG).
module press_event_encoder
    import press_evt_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LONG_TH = 1000,
    parameter int unsigned DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             db_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [CNT_W+1:0] evt_data_o,
    output logic             overflow_o
);

    localparam int unsigned    CntW   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DurMax = '1;
    localparam logic [CNT_W-1:0] LongTh = CNT_W'(LONG_TH);

    state_e           state_q, state_d;
    logic             db_q;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic             rise, fall;

    logic             push;
    evt_type_e        push_type;
    logic [CNT_W-1:0] push_dur;
    logic             pop;
    logic             ovf_q;

    logic [CNT_W+1:0] fifo_data;
    logic             fifo_full, fifo_empty;
    logic [CntW-1:0]  fifo_count;

    assign rise = db_i & ~db_q;
    assign fall = ~db_i & db_q;

    always_comb begin
        state_d   = state_q;
        dur_d     = dur_q;
        push      = 1'b0;
        push_type = EVT_NONE;
        push_dur  = '0;
        unique case (state_q)
            // A level already high at reset release is not a press.
            WAIT_LOW: if (!db_i) state_d = IDLE;
            IDLE: begin
                if (rise) begin
                    dur_d   = CNT_W'(1);
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    push      = 1'b1;
                    push_type = (dur_q >= LongTh) ? EVT_LONG : EVT_SHORT;
                    push_dur  = dur_q;
                    dur_d     = '0;
                    state_d   = IDLE;
                end else begin
                    dur_d = (dur_q == DurMax) ? dur_q : dur_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
`ifdef PRESS_HOLD_EVT_EN
        // dur is cleared on release, so this fires exactly once per press,
        // including LONG_TH == 1 on the rise cycle.
        if (state_d == PRESSED && dur_d == LongTh && dur_q != LongTh) begin
            push      = 1'b1;
            push_type = EVT_HOLD;
            push_dur  = LongTh;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_LOW;
            db_q    <= 1'b0;
            dur_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            db_q    <= db_i;
            dur_q   <= dur_d;
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    evt_fifo #(
        .Depth (DEPTH),
        .Width (CNT_W + 2)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  ({push_type, push_dur}),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign evt_valid_o = ~fifo_empty;
    assign pop         = evt_valid_o & evt_ready_i;
    // Storage is not reset; mask so the port reads zero while nothing is queued.
    assign evt_data_o  = evt_valid_o ? fifo_data : '0;
    assign overflow_o  = ovf_q;

    full_means_depth_a: assert property (@(posedge clk) disable iff (rst)
        fifo_full |-> (fifo_count == CntW'(DEPTH)));

endmodule

// File: tb/tb_press_event_encoder.sv
module tb_press_event_encoder;

    localparam int CW   = 8;
    localparam int TH   = 20;
    localparam int D    = 4;
    localparam int MAXD = 255;

    logic          clk = 1'b0;
    logic          rst, db, rdy;
    logic          valid, ovf;
    logic [CW+1:0] data;

    always #5 clk = ~clk;

    press_event_encoder #(
        .CNT_W   (CW),
        .LONG_TH (TH),
        .DEPTH   (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .db_i        (db),
        .evt_valid_o (valid),
        .evt_ready_i (rdy),
        .evt_data_o  (data),
        .overflow_o  (ovf)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: queue of events expected in the FIFO plus press bookkeeping.
    logic [CW+1:0] mq[$];
    bit            m_ovf     = 1'b0;
    bit            m_armed   = 1'b0;
    bit            m_pressed = 1'b0;
    int            m_len     = 0;
    bit            rand_rdy  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW+1:0] mk(input logic [1:0] t, input int len);
        return {t, CW'(len > MAXD ? MAXD : len)};
    endfunction

    task automatic push_evt(input logic [CW+1:0] e);
        if (mq.size() < D) mq.push_back(e);
        else m_ovf = 1'b1;
    endtask

    // One model cycle: compare registered outputs, then apply this cycle's inputs.
    task automatic model_step();
        bit pop;
        chk("valid", valid, mq.size() > 0);
        chk("overflow", ovf, m_ovf);
        if (mq.size() > 0) chk("head_data", data, mq[0]);
        pop = (mq.size() > 0) && rdy;
        if (rst) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_armed   = 1'b0;
            m_pressed = 1'b0;
            m_len     = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!db) begin
                if (m_pressed) push_evt(mk(m_len >= TH ? 2'b10 : 2'b01, m_len));
                m_pressed = 1'b0;
                m_armed   = 1'b1;
            end else if (m_armed) begin
                if (m_pressed) m_len++;
                else begin
                    m_pressed = 1'b1;
                    m_len     = 1;
                end
`ifdef PRESS_HOLD_EVT_EN
                if (m_len == TH) push_evt(mk(2'b11, TH));
`endif
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse(input int n, input int gap);
        db = 1'b1;
        repeat (n) cyc();
        db = 1'b0;
        repeat (gap) cyc();
    endtask

    initial begin
        rst = 1'b1;
        db  = 1'b1;
        rdy = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_overflow", ovf, 0);

        // Level high through reset is ignored; only the later 5-cycle pulse counts.
        repeat (10) cyc();
        db = 1'b0;
        repeat (3) cyc();
        pulse(5, 4);

        // Threshold boundary and saturation.
        pulse(19, 3);
        pulse(20, 3);
        pulse(30, 3);
        pulse(300, 4);

        // Overflow: five events into four slots while stalled, then drain.
        rdy = 1'b0;
        repeat (5) pulse(3, 2);
        chk("ovf_after_5th", ovf, 1);
        rdy = 1'b1;
        repeat (8) cyc();

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (2) cyc();
        chk("ovf_cleared", ovf, 0);

        // Full FIFO with a pop in the same cycle as the fall: nothing dropped.
        rdy = 1'b0;
        repeat (4) pulse(3, 2);
        db = 1'b1;
        repeat (3) cyc();
        db  = 1'b0;
        rdy = 1'b1;
        cyc();
        rdy = 1'b0;
        repeat (3) cyc();
        chk("full_pop_push_valid", valid, 1);
        chk("full_pop_push_ovf", ovf, 0);
        rdy = 1'b1;
        repeat (8) cyc();

        // Reset mid-press with two events queued.
        rdy = 1'b0;
        repeat (2) pulse(3, 2);
        db = 1'b1;
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        chk("midpress_rst_valid", valid, 0);
        chk("midpress_rst_ovf", ovf, 0);
        db = 1'b0;
        cyc();
        rdy = 1'b1;
        pulse(4, 3);
        pulse(25, 4);

        // Random pulses against random consumer back-pressure.
        rand_rdy = 1'b1;
        repeat (30) pulse($urandom_range(1, 45), $urandom_range(1, 8));
        rand_rdy = 1'b0;
        rdy      = 1'b1;
        db       = 1'b0;
        repeat (12) cyc();
        chk("drained", valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
